// File: rtl/vga_timing_pattern_gen_if.sv
// Pixel-stream bundle between the VGA timing/pattern generator and its consumer.
// master = generator (drives sync, colour and position); slave = the DAC/consumer side.
// mode and solid_rgb travel with the bundle as configuration inputs to the generator.
interface vga_timing_pattern_gen_if #(
  parameter int COLOR_W = 8,
  parameter int CNT_W   = 11
);
  logic [1:0]           mode;
  logic [3*COLOR_W-1:0] solid_rgb;
  logic                 VGA_HS;
  logic                 VGA_VS;
  logic                 VGA_BLANK;
  logic [COLOR_W-1:0]   VGA_R;
  logic [COLOR_W-1:0]   VGA_G;
  logic [COLOR_W-1:0]   VGA_B;
  logic [CNT_W-1:0]     pix_x;
  logic [CNT_W-1:0]     pix_y;
  logic                 sof;
  logic [15:0]          frame_cnt;

  modport master (
    input  mode, solid_rgb,
    output VGA_HS, VGA_VS, VGA_BLANK, VGA_R, VGA_G, VGA_B,
           pix_x, pix_y, sof, frame_cnt
  );

  modport slave (
    output mode, solid_rgb,
    input  VGA_HS, VGA_VS, VGA_BLANK, VGA_R, VGA_G, VGA_B,
           pix_x, pix_y, sof, frame_cnt
  );
endinterface

// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA raster timing plus four test patterns (solid, bars, gradient, checker).
// Latency: 1 cycle from the stage-0 h/v counters to every registered output, all aligned.
// Backpressure: none; free-running on the pixel clock, the consumer must keep up.
module vga_timing_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8,
  parameter int CNT_W    = 11,
  parameter int CHK_LOG2 = 5
) (
  input logic                      clk25MHz,
  input logic                      reset,
  vga_timing_pattern_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0]   h;
  logic [CNT_W-1:0]   v;
  logic [1:0]         mode_q;
  logic               frame_start;
  logic [1:0]         eff_mode;
  logic [2:0]         bar_idx;
  logic               de_n;
  logic               hs_on;
  logic               vs_on;
  logic               chk;
  logic [CNT_W-1:0]   hv_sum;
  logic [COLOR_W-1:0] r_n;
  logic [COLOR_W-1:0] g_n;
  logic [COLOR_W-1:0] b_n;

  // Pixel (0,0) is the frame boundary; the new frame's mode applies to it immediately,
  // so the pattern mux sees the live input on that one pixel and the latched copy after.
  assign frame_start = (h == '0) && (v == '0);
  assign eff_mode    = frame_start ? vga.mode : mode_q;

  // Stage 0: raster counters, h wraps every line, v advances on the last pixel of a line.
  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + CNT_W'(1);
    end else begin
      h <= h + CNT_W'(1);
    end
  end

  // Frame-latched pattern select so a mid-frame change never tears the image.
  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      mode_q <= 2'd0;
    end else if (frame_start) begin
      mode_q <= vga.mode;
    end
  end

  // Pattern and timing decode for the current stage-0 pixel.
  always_comb begin
    bar_idx = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (h < CNT_W'((i + 1) * BAR_W)) bar_idx = 3'(i);
    end
    de_n   = (h < H_ACT) && (v < V_ACT);
    hs_on  = (h >= HS_START) && (h < HS_END);
    vs_on  = (v >= VS_START) && (v < VS_END);
    chk    = h[CHK_LOG2] ^ v[CHK_LOG2];
    hv_sum = h + v;
    r_n    = '0;
    g_n    = '0;
    b_n    = '0;
    case (eff_mode)
      2'd0: {r_n, g_n, b_n} = vga.solid_rgb;
      // Bar colours follow the index bits: R off for 2,3,6,7; G off for 4..7; B off for odd.
      2'd1: begin
        r_n = {COLOR_W{~bar_idx[1]}};
        g_n = {COLOR_W{~bar_idx[2]}};
        b_n = {COLOR_W{~bar_idx[0]}};
      end
      2'd2: begin
        r_n = h[COLOR_W-1:0];
        g_n = v[COLOR_W-1:0];
        b_n = hv_sum[COLOR_W-1:0];
      end
      default: begin
        r_n = {COLOR_W{~chk}};
        g_n = {COLOR_W{~chk}};
        b_n = {COLOR_W{~chk}};
      end
    endcase
    if (!de_n) begin
      r_n = '0;
      g_n = '0;
      b_n = '0;
    end
  end

  // Stage 1: every output registered from the same stage-0 pixel so they stay aligned.
  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      vga.VGA_HS    <= ~HS_POL;
      vga.VGA_VS    <= ~VS_POL;
      vga.VGA_BLANK <= 1'b0;
      vga.VGA_R     <= '0;
      vga.VGA_G     <= '0;
      vga.VGA_B     <= '0;
      vga.pix_x     <= '0;
      vga.pix_y     <= '0;
      vga.sof       <= 1'b0;
      vga.frame_cnt <= 16'd0;
    end else begin
      vga.VGA_HS    <= hs_on ? HS_POL : ~HS_POL;
      vga.VGA_VS    <= vs_on ? VS_POL : ~VS_POL;
      vga.VGA_BLANK <= de_n;
      vga.VGA_R     <= r_n;
      vga.VGA_G     <= g_n;
      vga.VGA_B     <= b_n;
      vga.pix_x     <= h;
      vga.pix_y     <= v;
      vga.sof       <= frame_start;
      if (frame_start) vga.frame_cnt <= vga.frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench for vga_timing_pattern_gen: a default 640x480 instance and a tiny-raster instance
// checked every cycle against a coordinate-based reference model plus fixed spot values.
module tb_vga_timing_pattern_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [10:0] px;
    logic [10:0] py;
    logic        sof;
    logic [15:0] fc;
  } vout_t;

  localparam int A_HT  = 800;
  localparam int A_VT  = 525;
  localparam int A_TOT = A_HT * A_VT;
  localparam int B_HT  = 14;
  localparam int B_VT  = 7;
  localparam int B_TOT = B_HT * B_VT;

  logic clk25MHz = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #20 clk25MHz = ~clk25MHz;

  vga_timing_pattern_gen_if #(.COLOR_W(8), .CNT_W(11)) ifa ();
  vga_timing_pattern_gen_if #(.COLOR_W(8), .CNT_W(11)) ifb ();

  vga_timing_pattern_gen dut_a (
    .clk25MHz (clk25MHz),
    .reset    (reset),
    .vga      (ifa)
  );

  vga_timing_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut_b (
    .clk25MHz (clk25MHz),
    .reset    (reset),
    .vga      (ifb)
  );

  vout_t       got_a, got_b, exp_a, exp_b;
  logic [23:0] rgb_a, rgb_b;
  assign got_a = {ifa.VGA_HS, ifa.VGA_VS, ifa.VGA_BLANK, ifa.VGA_R, ifa.VGA_G, ifa.VGA_B,
                  ifa.pix_x, ifa.pix_y, ifa.sof, ifa.frame_cnt};
  assign got_b = {ifb.VGA_HS, ifb.VGA_VS, ifb.VGA_BLANK, ifb.VGA_R, ifb.VGA_G, ifb.VGA_B,
                  ifb.pix_x, ifb.pix_y, ifb.sof, ifb.frame_cnt};
  assign rgb_a = {ifa.VGA_R, ifa.VGA_G, ifa.VGA_B};
  assign rgb_b = {ifb.VGA_R, ifb.VGA_G, ifb.VGA_B};

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Reference pixel from raster coordinates using plain arithmetic.
  function automatic vout_t model_pix(input int ha, hf, hsw, va, vf, vsw,
                                      input bit hpol, vpol, input int x, y,
                                      input logic [1:0] md, input logic [23:0] solid);
    vout_t       o;
    logic [23:0] rgb;
    int          idx;
    o       = '0;
    rgb     = 24'h0;
    o.hs    = (x >= ha + hf && x < ha + hf + hsw) ? hpol : !hpol;
    o.vs    = (y >= va + vf && y < va + vf + vsw) ? vpol : !vpol;
    o.blank = (x < ha) && (y < va);
    case (md)
      2'd0: rgb = solid;
      2'd1: begin
        idx = (ha / 8 == 0) ? 7 : x / (ha / 8);
        if (idx > 7) idx = 7;
        rgb = bar_tab[idx];
      end
      2'd2: rgb = {8'(x), 8'(y), 8'(x + y)};
      default: rgb = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
    endcase
    if (!o.blank) rgb = 24'h0;
    {o.r, o.g, o.b} = rgb;
    o.px = 11'(x);
    o.py = 11'(y);
    return o;
  endfunction

  // Reference model: pixel index = edges since reset release, frame mode captured at index 0.
  int         na, nb, pa, pb;
  logic [1:0] fm_a, fm_b;
  always @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      na = 0; nb = 0; fm_a = 2'd0; fm_b = 2'd0;
      exp_a = '0; exp_a.hs = 1'b1; exp_a.vs = 1'b1;
      exp_b = '0; exp_b.hs = 1'b0; exp_b.vs = 1'b1;
    end else begin
      pa = na % A_TOT;
      if (pa == 0) fm_a = ifa.mode;
      exp_a = model_pix(640, 16, 96, 480, 10, 2, 1'b0, 1'b0, pa % A_HT, pa / A_HT, fm_a, ifa.solid_rgb);
      exp_a.sof = (pa == 0);
      exp_a.fc  = 16'(na / A_TOT + 1);
      na++;
      pb = nb % B_TOT;
      if (pb == 0) fm_b = ifb.mode;
      exp_b = model_pix(8, 2, 3, 4, 1, 1, 1'b1, 1'b0, pb % B_HT, pb / B_HT, fm_b, ifb.solid_rgb);
      exp_b.sof = (pb == 0);
      exp_b.fc  = 16'(nb / B_TOT + 1);
      nb++;
    end
  end

  // Pulse reset; the first edge after this returns presents pixel (0,0).
  task automatic restart();
    @(posedge clk25MHz); #3 reset = 1'b1;
    @(posedge clk25MHz); #3 reset = 1'b0;
  endtask

  task automatic test_reset();
    ifa.mode = 2'd0; ifa.solid_rgb = 24'h0;
    ifb.mode = 2'd0; ifb.solid_rgb = 24'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk25MHz);
    #2;
    checks++;
    if (got_a !== {1'b1, 1'b1, 64'h0}) begin
      errors++; $display("FAIL reset_a got=%h exp=%h", got_a, {1'b1, 1'b1, 64'h0});
    end
    checks++;
    if (got_b !== {1'b0, 1'b1, 64'h0}) begin
      errors++; $display("FAIL reset_b got=%h exp=%h", got_b, {1'b0, 1'b1, 64'h0});
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_bars();
    int x, y, hs_cnt, hs_first, hs_last;
    logic [23:0] want;
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    ifa.mode = 2'd1; ifb.mode = 2'($urandom_range(3));
    restart();
    for (int i = 0; i < 1700; i++) begin
      @(posedge clk25MHz); #2;
      x = i % A_HT; y = i / A_HT;
      checks++;
      if (got_a !== exp_a) begin
        errors++; $display("FAIL bars_pixel_a i=%0d got=%h exp=%h", i, got_a, exp_a);
      end
      checks++;
      if (got_b !== exp_b) begin
        errors++; $display("FAIL bars_pixel_b i=%0d got=%h exp=%h", i, got_b, exp_b);
      end
      if (i == 0) begin
        checks++;
        if (ifa.sof !== 1'b1 || ifa.frame_cnt !== 16'd1) begin
          errors++; $display("FAIL first_sof sof=%b fc=%0d exp sof=1 fc=1", ifa.sof, ifa.frame_cnt);
        end
      end
      if (y == 0 && (x == 0 || x == 80 || x == 400 || x == 639 || x == 640)) begin
        case (x)
          0:       want = 24'hFFFFFF;
          80:      want = 24'hFFFF00;
          400:     want = 24'hFF0000;
          default: want = 24'h000000;
        endcase
        checks++;
        if (rgb_a !== want) begin
          errors++; $display("FAIL bar_spot x=%0d got=%h exp=%h", x, rgb_a, want);
        end
      end
      if (y == 1 && ifa.VGA_HS == 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(ifa.pix_x);
        hs_last = int'(ifa.pix_x);
      end
      ifa.mode = 2'($urandom_range(3)); ifa.solid_rgb = 24'($urandom);
      ifb.mode = 2'($urandom_range(3)); ifb.solid_rgb = 24'($urandom);
    end
    checks++;
    if (hs_cnt != 96) begin
      errors++; $display("FAIL hsync_width got=%0d exp=96", hs_cnt);
    end
    checks++;
    if (hs_first != 656 || hs_last != 751) begin
      errors++; $display("FAIL hsync_pos got=%0d..%0d exp=656..751", hs_first, hs_last);
    end
  endtask

  task automatic test_checker();
    int x, y;
    logic [23:0] want;
    ifa.mode = 2'd3;
    restart();
    for (int i = 0; i <= 32 * A_HT + 32; i++) begin
      @(posedge clk25MHz); #2;
      x = i % A_HT; y = i / A_HT;
      checks++;
      if (got_a !== exp_a) begin
        errors++; $display("FAIL checker_pixel_a i=%0d got=%h exp=%h", i, got_a, exp_a);
      end
      if ((x == 0 && y == 0) || (x == 32 && y == 0) || (x == 32 && y == 32)) begin
        want = (x == 32 && y == 0) ? 24'h000000 : 24'hFFFFFF;
        checks++;
        if (rgb_a !== want) begin
          errors++; $display("FAIL checker_spot x=%0d y=%0d got=%h exp=%h", x, y, rgb_a, want);
        end
      end
      ifa.mode = 2'($urandom_range(3)); ifa.solid_rgb = 24'($urandom);
    end
  endtask

  task automatic test_gradient_reset();
    int x, y;
    ifa.mode = 2'd2;
    restart();
    for (int i = 0; i <= 10 * A_HT + 400; i++) begin
      @(posedge clk25MHz); #2;
      x = i % A_HT; y = i / A_HT;
      checks++;
      if (got_a !== exp_a) begin
        errors++; $display("FAIL gradient_pixel_a i=%0d got=%h exp=%h", i, got_a, exp_a);
      end
      if (x == 300 && y == 10) begin
        checks++;
        if (rgb_a !== 24'h2C0A36) begin
          errors++; $display("FAIL gradient_300_10 got=%h exp=2C0A36", rgb_a);
        end
      end
      if (x == 639 && y == 5) begin
        checks++;
        if (rgb_a !== 24'h7F0584) begin
          errors++; $display("FAIL gradient_639_5 got=%h exp=7F0584", rgb_a);
        end
      end
      ifa.mode = 2'($urandom_range(3)); ifa.solid_rgb = 24'($urandom);
    end
    // Now presenting (400,10): reset between edges must clear outputs at once.
    #1 reset = 1'b1;
    #1;
    checks++;
    if (got_a !== {1'b1, 1'b1, 64'h0}) begin
      errors++; $display("FAIL midline_reset_a got=%h exp=%h", got_a, {1'b1, 1'b1, 64'h0});
    end
    checks++;
    if (got_b !== {1'b0, 1'b1, 64'h0}) begin
      errors++; $display("FAIL midline_reset_b got=%h exp=%h", got_b, {1'b0, 1'b1, 64'h0});
    end
    ifa.mode = 2'd2;
    @(posedge clk25MHz); #3 reset = 1'b0;
    @(posedge clk25MHz); #2;
    checks++;
    if (ifa.sof !== 1'b1 || ifa.pix_x !== 11'd0 || ifa.pix_y !== 11'd0 || ifa.frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL restart_origin sof=%b x=%0d y=%0d fc=%0d exp sof=1 x=0 y=0 fc=1",
               ifa.sof, ifa.pix_x, ifa.pix_y, ifa.frame_cnt);
    end
    checks++;
    if (got_a !== exp_a) begin
      errors++; $display("FAIL restart_pixel_a got=%h exp=%h", got_a, exp_a);
    end
  endtask

  task automatic test_small_frames();
    int sof_cnt, last_sof, hs_hi, vs_lo;
    sof_cnt = 0; last_sof = -1; hs_hi = 0; vs_lo = 0;
    ifb.mode = 2'($urandom_range(3));
    restart();
    for (int i = 0; i < 20 * B_TOT; i++) begin
      @(posedge clk25MHz); #2;
      checks++;
      if (got_b !== exp_b) begin
        errors++; $display("FAIL small_pixel_b i=%0d got=%h exp=%h", i, got_b, exp_b);
      end
      if (ifb.sof === 1'b1) begin
        sof_cnt++;
        if (last_sof >= 0) begin
          checks++;
          if (i - last_sof != B_TOT) begin
            errors++; $display("FAIL sof_period got=%0d exp=%0d", i - last_sof, B_TOT);
          end
        end
        last_sof = i;
      end
      if (ifb.VGA_HS === 1'b1) begin
        hs_hi++;
        checks++;
        if (ifb.pix_x < 11'd10 || ifb.pix_x > 11'd12) begin
          errors++; $display("FAIL hsync_b_pos got=%0d exp=10..12", ifb.pix_x);
        end
      end
      if (ifb.VGA_VS === 1'b0) vs_lo++;
      ifb.mode = 2'($urandom_range(3)); ifb.solid_rgb = 24'($urandom);
    end
    checks++;
    if (sof_cnt != 20) begin
      errors++; $display("FAIL sof_count_b got=%0d exp=20", sof_cnt);
    end
    checks++;
    if (hs_hi != 420) begin
      errors++; $display("FAIL hsync_b_total got=%0d exp=420", hs_hi);
    end
    checks++;
    if (vs_lo != 280) begin
      errors++; $display("FAIL vsync_b_total got=%0d exp=280", vs_lo);
    end
  endtask

  task automatic test_mode_switch();
    ifb.mode = 2'd0; ifb.solid_rgb = 24'h3C5AA5;
    restart();
    for (int i = 0; i < 2 * B_TOT; i++) begin
      @(posedge clk25MHz); #2;
      checks++;
      if (got_b !== exp_b) begin
        errors++; $display("FAIL switch_pixel_b i=%0d got=%h exp=%h", i, got_b, exp_b);
      end
      if (ifb.VGA_BLANK === 1'b1) begin
        checks++;
        if (i < B_TOT && rgb_b !== 24'h3C5AA5) begin
          errors++; $display("FAIL switch_hold i=%0d got=%h exp=3C5AA5", i, rgb_b);
        end else if (i >= B_TOT && rgb_b !== 24'hFFFFFF) begin
          errors++; $display("FAIL switch_next i=%0d got=%h exp=FFFFFF", i, rgb_b);
        end
      end
      if (i == B_TOT) begin
        checks++;
        if (ifb.sof !== 1'b1 || ifb.frame_cnt !== 16'd2) begin
          errors++; $display("FAIL second_sof sof=%b fc=%0d exp sof=1 fc=2", ifb.sof, ifb.frame_cnt);
        end
      end
      if (i == 2 * B_HT + 3) ifb.mode = 2'd3;
    end
  endtask

  initial begin
    test_reset();
    test_bars();
    test_checker();
    test_gradient_reset();
    test_small_frames();
    test_mode_switch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
